rrp_otf_conv: RTL

Downstream stage of the parallel radix-r signed-digit adder. Accepts one redundant signed-digit word (the adder's registered sum, WIDTH digits) through a valid/ready handshake. Converts it MSD-first, one digit per clock, to a conventional two's-complement integer using on-the-fly conversion (Q/QM registers). Presents the result on a held output with its own valid/ready handshake.

---
 rtl/rrp_otf_conv.sv | 127 ++++++++++++
 1 files changed

// File: rtl/rrp_otf_conv.sv
// On-the-fly conversion of one radix-RADIX signed-digit word (MSD first, one digit
// per clock) into a two's-complement integer, with valid/ready on both sides.
module rrp_otf_conv #(
    parameter int RADIX = 8,
    parameter int WIDTH = 6,
    localparam int K = $clog2(RADIX),
    localparam int D = K + 1,
    localparam int N = D * WIDTH,
    localparam int B = K * WIDTH + 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [B-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [B-1:0] RADIX_B    = B'(RADIX);
    localparam logic [B-1:0] RADIX_M1_B = B'(RADIX - 1);
    localparam logic [B-1:0] ONE_B      = B'(1);
    localparam logic [D-1:0] ILLEGAL    = {1'b1, {K{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   word_reg, word_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [B-1:0]   q_reg, q_next;
    logic [B-1:0]   qm_reg, qm_next;
    logic           err_reg, err_next;

    logic [D-1:0]   digit_arr [WIDTH];
    logic [D-1:0]   d_raw;
    logic [B-1:0]   d_ext;
    logic [B-1:0]   q_shift;
    logic [B-1:0]   qm_shift;
    logic           d_neg;
    logic           d_zero;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_digit
            assign digit_arr[gi] = word_reg[gi*D +: D];
        end
    endgenerate

    assign d_raw    = digit_arr[cnt_reg];
    assign d_ext    = B'($signed(d_raw));
    assign d_neg    = d_raw[D-1];
    assign d_zero   = (d_raw == '0);
    assign q_shift  = q_reg << K;
    assign qm_shift = qm_reg << K;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            word_reg  <= '0;
            cnt_reg   <= '0;
            q_reg     <= '0;
            qm_reg    <= '1;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            word_reg  <= word_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            qm_reg    <= qm_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        word_next  = word_reg;
        cnt_next   = cnt_reg;
        q_next     = q_reg;
        qm_next    = qm_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    word_next  = in_data;
                    cnt_next   = CW'(WIDTH - 1);
                    q_next     = '0;
                    qm_next    = '1;
                    err_next   = 1'b0;
                    state_next = CONV;
                end
            end
            CONV: begin
                // Q and QM = Q-1 are both kept so a negative digit never needs a borrow chain
                q_next  = d_neg ? (qm_shift + RADIX_B + d_ext) : (q_shift + d_ext);
                qm_next = (!d_neg && !d_zero) ? (q_shift + d_ext - ONE_B)
                                              : (qm_shift + RADIX_M1_B + d_ext);
                err_next = err_reg | (d_raw == ILLEGAL);
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_data  = q_reg;
    assign out_err   = err_reg;

endmodule
